// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared Game Boy system-bus constants and the OAM DMA state encoding.
// No ports; imported by the DMA master, its source-page mapper and the bench.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } dma_state_t;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_BYTES    = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  ECHO_OFFSET  = 8'h20;
  localparam logic [7:0]  ECHO_FIRST   = 8'hE0;

endpackage

// File: rtl/oam_dma_master_if.sv
// oam_dma_master_if: system-bus bundle between a bus initiator and the top-level mux.
// Ports: bus_grant (arbiter), bus_req/bus_drive, address_bus, nread/nwrite strobes.
interface oam_dma_master_if;

  logic        bus_grant;
  logic        bus_req;
  logic        bus_drive;
  logic [15:0] address_bus;
  logic        nread;
  logic        nwrite;

  modport master (
    input  bus_grant,
    output bus_req,
    output bus_drive,
    output address_bus,
    output nread,
    output nwrite
  );

  modport slave (
    output bus_grant,
    input  bus_req,
    input  bus_drive,
    input  address_bus,
    input  nread,
    input  nwrite
  );

endinterface

// File: rtl/oam_dma_srcmap.sv
// oam_dma_srcmap: folds echo-RAM pages 0xE0-0xFF onto WRAM pages 0xC0-0xDF.
// Ports: page (requested source page) -> src_page (page actually read).
module oam_dma_srcmap
  import gb_bus_pkg::*;
#(
  parameter bit ECHO_FOLD = 1'b1
) (
  input  logic [7:0] page,
  output logic [7:0] src_page
);

  assign src_page = (ECHO_FOLD && page >= ECHO_FIRST)
                  ? page - ECHO_OFFSET
                  : page;

endmodule

// File: rtl/oam_dma_master.sv
// oam_dma_master: OAM DMA bus initiator, copies {page,00..9F} to DEST_BASE.
// Ports: clock/reset, trigger+trigger_page, bus (master), data_bus, busy, page_reg, done.
module oam_dma_master
  import gb_bus_pkg::*;
#(
  parameter int          XFER_LEN  = OAM_BYTES,
  parameter logic [15:0] DEST_BASE = OAM_BASE,
  parameter bit          ECHO_FOLD = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trigger,
  input  logic [7:0]       trigger_page,
  oam_dma_master_if.master bus,
  inout  wire  [7:0]       data_bus,
  output logic             busy,
  output logic [7:0]       page_reg,
  output logic             done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state, state_n;
  logic [7:0] idx, idx_n;
  logic [7:0] page_n;
  logic [7:0] latch, latch_n;
  logic       done_n;
  logic [7:0] src_page;
  logic       active;
  logic       rd_on;
  logic       wr_on;

  oam_dma_srcmap #(
    .ECHO_FOLD(ECHO_FOLD)
  ) u_srcmap (
    .page    (page_reg),
    .src_page(src_page)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      page_reg <= '0;
      latch    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      page_reg <= page_n;
      latch    <= latch_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    page_n  = page_reg;
    latch_n = latch;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_REQ: begin
        if (bus.bus_grant) state_n = ST_RD;
      end
      ST_RD: begin
        if (bus.bus_grant) begin
          latch_n = data_bus;
          state_n = ST_WR;
        end
      end
      ST_WR: begin
        if (bus.bus_grant) begin
          if (idx == LAST_IDX) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 8'd1;
            state_n = ST_RD;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A new trigger always wins, even over the final write: no done.
    if (trigger) begin
      page_n = trigger_page;
      idx_n  = '0;
      done_n = 1'b0;
      if (state == ST_IDLE || !bus.bus_grant) state_n = ST_REQ;
      else                                     state_n = ST_RD;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign active = bus.bus_grant && (state == ST_RD || state == ST_WR);
  assign rd_on  = active && (state == ST_RD);
  assign wr_on  = active && (state == ST_WR);

  assign bus.bus_req   = busy;
  assign bus.bus_drive = active;
  assign bus.nread     = !rd_on;
  assign bus.nwrite    = !wr_on;

  always_comb begin
    bus.address_bus = 16'h0000;
    unique case (1'b1)
      rd_on:   bus.address_bus = {src_page, idx};
      wr_on:   bus.address_bus = DEST_BASE + {8'h00, idx};
      default: bus.address_bus = 16'h0000;
    endcase
  end

  assign data_bus = wr_on ? latch : 8'hzz;

endmodule

// File: tb/tb_oam_dma_master.sv
// tb_oam_dma_master: directed bench for the OAM DMA master with a bus memory model.
// Ports: none; drives clock/reset/trigger/grant and models WRAM reads and OAM writes.
module tb_oam_dma_master;
  import gb_bus_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic [7:0] trigger_page;
  wire  [7:0] data_bus;
  logic       busy;
  logic [7:0] page_reg;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rom [0:65535];
  logic [7:0]  oam [0:159];
  logic        oam_clr = 1'b0;
  int          stray = 0;
  int          done_total = 0;
  logic [15:0] rd_log [$];

  oam_dma_master_if bus_if ();

  oam_dma_master #(
    .XFER_LEN (160),
    .DEST_BASE(16'hFE00),
    .ECHO_FOLD(1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .trigger     (trigger),
    .trigger_page(trigger_page),
    .bus         (bus_if),
    .data_bus    (data_bus),
    .busy        (busy),
    .page_reg    (page_reg),
    .done        (done)
  );

  always #5 clock = ~clock;

  assign data_bus = (bus_if.bus_drive && !bus_if.nread)
                  ? rom[bus_if.address_bus] : 8'hzz;

  always @(posedge clock) begin
    if (oam_clr) begin
      for (int i = 0; i < 160; i++) oam[i] <= 8'hEE;
    end else if (bus_if.bus_drive && !bus_if.nwrite) begin
      if (bus_if.address_bus >= 16'hFE00 && bus_if.address_bus <= 16'hFE9F)
        oam[8'(bus_if.address_bus - 16'hFE00)] <= data_bus;
      else
        stray <= stray + 1;
    end
  end

  always @(negedge clock) begin
    if (done) done_total++;
    if (bus_if.bus_drive && !bus_if.nread) rd_log.push_back(bus_if.address_bus);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic trig(input logic [7:0] page);
    trigger      = 1'b1;
    trigger_page = page;
    @(negedge clock);
    trigger      = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic clear_oam();
    oam_clr = 1'b1;
    @(negedge clock);
    oam_clr = 1'b0;
  endtask

  function automatic int oam_bad(input logic [15:0] src, input int lo,
                                 input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      if (oam[i] !== rom[src + 16'(i)]) n++;
    return n;
  endfunction

  initial begin
    int cyc, extra, base, bad, dt, guard;

    for (int a = 0; a < 65536; a++) rom[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      rom[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      rom[16'hC100 + 16'(i)] = 8'(3 * i + 1);
      rom[16'hD000 + 16'(i)] = 8'(7 * i + 3);
      rom[16'hE100 + 16'(i)] = 8'hFF;
    end

    reset            = 1'b1;
    trigger          = 1'b0;
    trigger_page     = 8'h00;
    bus_if.bus_grant = 1'b0;
    #1;
    check("rst_req",   bus_if.bus_req,     0);
    check("rst_drive", bus_if.bus_drive,   0);
    check("rst_busy",  busy,               0);
    check("rst_done",  done,               0);
    check("rst_nrd",   bus_if.nread,       1);
    check("rst_nwr",   bus_if.nwrite,      1);
    check("rst_addr",  bus_if.address_bus, 0);
    check("rst_page",  page_reg,           0);
    @(negedge clock);
    reset = 1'b0;
    clear_oam();

    // 1: plain transfer from page C0 with grant tied high
    bus_if.bus_grant = 1'b1;
    dt = done_total;
    trig(8'hC0);
    check("t1_busy", busy, 1);
    wait_done(cyc);
    check("t1_cycles", cyc, 321);
    @(negedge clock);
    check("t1_done_pulse", done, 0);
    check("t1_busy_after", busy, 0);
    check("t1_req_after", bus_if.bus_req, 0);
    check("t1_done_cnt", done_total - dt, 1);
    check("t1_oam", oam_bad(16'hC000, 0, 159), 0);
    check("t1_page", page_reg, 8'hC0);

    // 2: echo page E1 folds to WRAM C1
    clear_oam();
    base = rd_log.size();
    trig(8'hE1);
    wait_done(cyc);
    @(negedge clock);
    check("t2_rd_count", rd_log.size() - base, 160);
    bad = 0;
    for (int k = 0; k < 160; k++)
      if (rd_log[base + k] !== 16'hC100 + 16'(k)) bad++;
    check("t2_rd_addr", bad, 0);
    check("t2_oam", oam_bad(16'hC100, 0, 159), 0);
    check("t2_page", page_reg, 8'hE1);

    // 3: grant lost for 7 cycles after byte 40's read
    clear_oam();
    trig(8'hC0);
    cyc = 0;
    while (!(bus_if.nread === 1'b0 && bus_if.address_bus === 16'hC028)
           && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    check("t3_rd40_at", cyc, 81);
    @(negedge clock);
    cyc++;
    check("t3_wr40_addr", bus_if.address_bus, 16'hFE28);
    bus_if.bus_grant = 1'b0;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (bus_if.nread !== 1'b1 || bus_if.nwrite !== 1'b1 ||
          bus_if.bus_drive !== 1'b0 || bus_if.bus_req !== 1'b1 ||
          busy !== 1'b1) bad++;
      @(negedge clock);
      cyc++;
    end
    check("t3_gap", bad, 0);
    bus_if.bus_grant = 1'b1;
    wait_done(extra);
    check("t3_cycles", cyc + extra, 328);
    @(negedge clock);
    check("t3_oam40", oam[40], 8'd40 ^ 8'h5A);
    check("t3_oam", oam_bad(16'hC000, 0, 159), 0);

    // 4: retrigger to page D0 while reading byte 80
    clear_oam();
    dt = done_total;
    trig(8'hC0);
    guard = 0;
    while (!(bus_if.nread === 1'b0 && bus_if.address_bus === 16'hC050)
           && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check("t4_rd80_at", guard, 161);
    trig(8'hD0);
    check("t4_rd_addr", bus_if.address_bus, 16'hD000);
    check("t4_rd_strobe", bus_if.nread, 0);
    wait_done(cyc);
    check("t4_cycles", cyc, 320);
    @(negedge clock);
    check("t4_done_cnt", done_total - dt, 1);
    check("t4_page", page_reg, 8'hD0);
    check("t4_oam", oam_bad(16'hD000, 0, 159), 0);

    // 5: reset while writing byte 100
    clear_oam();
    dt = done_total;
    trig(8'hC0);
    guard = 0;
    while (!(bus_if.nwrite === 1'b0 && bus_if.address_bus === 16'hFE64)
           && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check("t5_wr100_at", guard, 202);
    reset = 1'b1;
    #1;
    check("t5_nwr", bus_if.nwrite, 1);
    check("t5_nrd", bus_if.nread, 1);
    check("t5_drive", bus_if.bus_drive, 0);
    check("t5_req", bus_if.bus_req, 0);
    check("t5_busy", busy, 0);
    check("t5_page", page_reg, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    bad = 0;
    for (int i = 100; i < 160; i++) if (oam[i] !== 8'hEE) bad++;
    check("t5_oam_tail", bad, 0);
    check("t5_oam_head", oam_bad(16'hC000, 0, 99), 0);
    check("t5_no_done", done_total - dt, 0);
    check("t5_idle", busy, 0);

    // 6: trigger with grant withheld for 50 cycles
    clear_oam();
    bus_if.bus_grant = 1'b0;
    trig(8'hC0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_drive !== 1'b0 ||
          bus_if.nread !== 1'b1 || bus_if.nwrite !== 1'b1 ||
          busy !== 1'b1) bad++;
      @(negedge clock);
    end
    check("t6_wait", bad, 0);
    bus_if.bus_grant = 1'b1;
    @(negedge clock);
    check("t6_start_addr", bus_if.address_bus, 16'hC000);
    check("t6_start_rd", bus_if.nread, 0);
    check("t6_start_drive", bus_if.bus_drive, 1);
    wait_done(cyc);
    check("t6_cycles", cyc, 320);
    @(negedge clock);
    check("t6_oam", oam_bad(16'hC000, 0, 159), 0);
    check("stray_writes", stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_master.md
Name: oam_dma_master

Overview:
- Bus initiator for the Game Boy OAM DMA.
- A CPU write to the DMA register (0xFF46, decoded upstream) starts the transfer. The block arbitrates for the shared system bus, then copies 160 bytes from {page,0x00} to 0xFE00-0xFE9F.
- It drives the same address_bus/data_bus/nread/nwrite protocol the memory responders obey: read data is combinational during nread=0; writes commit at posedge while nwrite=0.
- It sits beside the CPU at the bus mux in the top level.

Parameters:
- XFER_LEN, 160, bytes per transfer (OAM size).
- DEST_BASE, 16'hFE00, destination base address.
- ECHO_FOLD, 1, when 1 source pages 0xE0-0xFF are read from page-0x20 (WRAM echo).

Ports:
- clock  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-high
- trigger  input  1  one-cycle pulse: CPU wrote the DMA register
- trigger_page  input  8  source page byte written with trigger
- bus_grant  input  1  arbiter grants bus to this master
- bus_req  output  1  request for bus ownership
- bus_drive  output  1  top level muxes this master's bus signals when 1
- address_bus  output  16  bus address
- data_bus  inout  8  bus data; driven only in WR with grant, else Z
- nread  output  1  active-low read strobe
- nwrite  output  1  active-low write strobe
- busy  output  1  transfer in progress
- page_reg  output  8  last written page (CPU readback of 0xFF46)
- done  output  1  one-cycle pulse on transfer completion

Behaviour:
- Reset (async, active-high) values:
  - state IDLE, idx 0, page_reg 0x00, latch 0x00.
  - bus_req 0, bus_drive 0, busy 0, done 0.
  - nread 1, nwrite 1, address_bus 0x0000, data_bus Z.
  - Reset mid-transfer aborts the transfer immediately; no further bus cycles occur.
- States: IDLE, REQ, RD, WR. State, idx, page_reg and latch are registers. Bus outputs decode combinationally from the registers and bus_grant.
- IDLE:
  - trigger=1 -> page_reg<=trigger_page, idx<=0, next REQ.
  - Otherwise hold.
- REQ:
  - bus_req=1, busy=1.
  - bus_grant=1 at posedge -> RD; else stay.
- RD, with grant:
  - bus_drive=1, nread=0, nwrite=1.
  - address_bus={src_page, idx[7:0]}. src_page=page_reg-0x20 if ECHO_FOLD and page_reg>=0xE0, else page_reg.
  - At posedge: latch<=data_bus, next WR.
- WR, with grant:
  - bus_drive=1, nread=1, nwrite=0, address_bus=DEST_BASE+idx, data_bus=latch.
  - At posedge: if idx==XFER_LEN-1 -> IDLE, done=1 for the following cycle, bus_req and busy drop.
  - Otherwise idx<=idx+1, next RD.
- Throughput and latency:
  - 2 cycles per byte.
  - Full transfer is 320 cycles of granted bus plus 1 REQ cycle minimum.
- Grant loss in RD/WR:
  - bus_drive=0, nread=1, nwrite=1, data_bus Z.
  - State, idx and latch hold (stall); bus_req stays 1.
  - The transfer resumes in the same state when grant returns. A stalled WR rewrites the held latch.
- Retrigger while busy:
  - page_reg<=trigger_page, idx<=0, state<=REQ if grant=0, else RD.
  - No done pulse is issued for the aborted transfer.
  - A trigger on the same edge as the final WR wins: restart, no done.
- idx: 8-bit, ranges 0..XFER_LEN-1, never wraps past XFER_LEN-1.
- Address arithmetic: DEST_BASE+idx is 16-bit with no carry out.
- busy=1 in REQ/RD/WR. page_reg always reflects the last trigger_page.

Decomposition:
- Shared package (gb_bus_pkg):
  - State encoding constants.
  - OAM_BASE 16'hFE00, OAM_BYTES 160, DMA_REG_ADDR 16'hFF46, ECHO_OFFSET 8'h20.
- Sub-module oam_dma_srcmap: combinational page->source-page fold, reusable by the CPU-side echo decoder.

Test Plan:
1. Memory preloaded 0xC000+i=i^0x5A, grant tied 1, trigger page 0xC0 -> OAM[i]=i^0x5A for i=0..159. done pulses exactly 321 cycles after trigger; busy low afterwards.
2. Trigger page 0xE1, ECHO_FOLD=1 -> every RD shows address_bus 0xC100..0xC19F, OAM matches WRAM 0xC100 page.
3. Grant dropped for 7 cycles after byte 40's RD -> during the gap nread=nwrite=1 and data_bus Z. OAM[40] is still correct; done is delayed by exactly 7 cycles.
4. Retrigger with page 0xD0 at byte 80 -> next RD address 0xD000. OAM ends with page 0xD0 contents only, single done pulse, page_reg=0xD0.
5. Reset asserted mid-WR at byte 100 -> same cycle nwrite=1, data_bus Z, bus_req 0, busy 0. OAM[100..159] unchanged.
6. Trigger with grant held 0 for 50 cycles -> bus_req=1, bus_drive=0, no strobes. Transfer starts on the cycle after grant rises.
